// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// FSM state encoding, default data width and a width helper.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_PIPE = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int W_DEF = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mul32.sv
// Combinational 32-bit multiplier, low half of the product.
// Ports: a, b operands; p = (a*b)[31:0].
module mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    assign p = a * b;

endmodule

// File: rtl/rr_pick.sv
// Round-robin selector: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx, any out.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = PW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one mul32 among NREQ requesters, round-robin, one op at a time.
// Ports: clk, reset (sync, high); req_valid/req_a/req_b in,
// req_ready out; rsp_valid/rsp_data out, rsp_ack in; busy out.
// Macro MUL_ARB_PIPE_EN adds a result register stage (PIPE state).
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEF,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] rsp_valid,
    output logic [W-1:0]    rsp_data,
    input  logic [NREQ-1:0] rsp_ack,
    output logic            busy
);

    localparam int PW = clog2(NREQ);

    state_t state, state_nx;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   own;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_any;
    logic [NREQ-1:0] own_oh;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    prod;
    logic [3:0]      cnt;
    logic            ld;
    logic            cap;
    logic            done;
`ifdef MUL_ARB_PIPE_EN
    logic [W-1:0]    pipe_q;
    logic            fwd;
`endif

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Operands come from registers, so the multiplier
    // only has to settle within the LAT-cycle window.
    mul32 u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    assign own_oh = NREQ'(1) << own;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        ld        = 1'b0;
        cap       = 1'b0;
        done      = 1'b0;
`ifdef MUL_ARB_PIPE_EN
        fwd       = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_gnt;
                    ld        = 1'b1;
                    state_nx  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    cap = 1'b1;
`ifdef MUL_ARB_PIPE_EN
                    state_nx = ST_PIPE;
`else
                    state_nx = ST_RESP;
`endif
                end
            end
            ST_PIPE: begin
`ifdef MUL_ARB_PIPE_EN
                fwd      = 1'b1;
                state_nx = ST_RESP;
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_RESP: begin
                // Only the owner's ack completes the transaction.
                if (rsp_ack[own]) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            own       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
`ifdef MUL_ARB_PIPE_EN
            pipe_q    <= '0;
`endif
        end else begin
            if (ld) begin
                op_a <= req_a[int'(pick_idx)*W +: W];
                op_b <= req_b[int'(pick_idx)*W +: W];
                own  <= pick_idx;
                cnt  <= 4'(LAT - 1);
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
`ifdef MUL_ARB_PIPE_EN
            if (cap) pipe_q <= prod;
            if (fwd) begin
                rsp_data  <= pipe_q;
                rsp_valid <= own_oh;
            end
`else
            if (cap) begin
                rsp_data  <= prod;
                rsp_valid <= own_oh;
            end
`endif
            // Pointer moves past the owner only once it is served.
            if (done) begin
                rsp_valid <= '0;
                if (own == PW'(NREQ - 1)) rr_ptr <= '0;
                else                      rr_ptr <= own + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed self-checking bench for mul_share_arb (NREQ=4, W=32, LAT=2).
// Expected values are hand-computed constants.
module tb_mul_share_arb;

`ifdef MUL_ARB_PIPE_EN
    localparam int LATC = 4;
`else
    localparam int LATC = 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [3:0]   rsp_ack;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mul_share_arb #(
        .NREQ (4),
        .W    (32),
        .LAT  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i,
                          input logic [31:0] a,
                          input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Expects requester i to win this IDLE cycle, then
    // checks latency, result and completes with an ack.
    task automatic serve(input int i,
                         input logic [31:0] exp,
                         input bit drop,
                         input string tag);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << i;
        #1;
        chk({tag, "_rdy"}, {28'd0, req_ready}, {28'd0, oh});
        tick();
        if (drop) req_valid[i] = 1'b0;
        n = 1;
        while (rsp_valid == 4'd0 && n < 20) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_rdy0"}, {28'd0, req_ready}, 32'd0);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, LATC);
        chk({tag, "_vld"}, {28'd0, rsp_valid}, {28'd0, oh});
        chk({tag, "_dat"}, rsp_data, exp);
        rsp_ack[i] = 1'b1;
        tick();
        rsp_ack = '0;
        chk({tag, "_vld0"}, {28'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ack   = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_vld", {28'd0, rsp_valid}, 32'd0);
        chk("rst_dat", rsp_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {28'd0, req_ready}, 32'd0);
        tick();

        // single request 1*1
        set_op(0, 32'd1, 32'd1);
        req_valid[0] = 1'b1;
        serve(0, 32'h0000_0001, 1'b1, "single");

        // wide operands, requester 2
        set_op(2, 32'h0000_FFFF, 32'h0000_FFFF);
        req_valid[2] = 1'b1;
        serve(2, 32'hFFFE_0001, 1'b1, "wide0");
        set_op(2, 32'hFFFF_FFFF, 32'd2);
        req_valid[2] = 1'b1;
        serve(2, 32'hFFFF_FFFE, 1'b1, "wide1");
        set_op(2, 32'h0001_0000, 32'h0001_0000);
        req_valid[2] = 1'b1;
        serve(2, 32'h0000_0000, 1'b1, "wide2");

        // reset pointer, then all four contend: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 32'd10);
        req_valid = 4'b1111;
        serve(0, 32'd10, 1'b0, "rr0");
        serve(1, 32'd20, 1'b0, "rr1");
        serve(2, 32'd30, 1'b0, "rr2");
        serve(3, 32'd40, 1'b0, "rr3");
        req_valid = 4'b0001;
        serve(0, 32'd10, 1'b1, "rr4");

        // delayed ack on requester 1 (pointer now 1)
        set_op(1, 32'd7, 32'd6);
        set_op(0, 32'd3, 32'd5);
        req_valid[1] = 1'b1;
        #1;
        chk("dly_rdy", {28'd0, req_ready}, 32'd2);
        tick();
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1;
        for (int c = 0; c < LATC - 1; c++) tick();
        for (int c = 0; c < 10; c++) begin
            rsp_ack[3] = (c == 3);
            #1;
            chk("dly_vld", {28'd0, rsp_valid}, 32'd2);
            chk("dly_dat", rsp_data, 32'd42);
            chk("dly_rdy0", {28'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ack = 4'b0010;
        tick();
        rsp_ack = '0;
        chk("dly_vld0", {28'd0, rsp_valid}, 32'd0);
        // pointer 2: pending requester 0 wins by wrap
        serve(0, 32'd15, 1'b1, "dly_next");

        // reset while requester 0 is in BUSY
        set_op(0, 32'd5, 32'd5);
        req_valid[0] = 1'b1;
        #1;
        chk("abrt_rdy", {28'd0, req_ready}, 32'd1);
        tick();
        req_valid = '0;
        chk("abrt_busy1", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abrt_vld", {28'd0, rsp_valid}, 32'd0);
        chk("abrt_dat", rsp_data, 32'd0);
        chk("abrt_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("abrt_novld", {28'd0, rsp_valid}, 32'd0);
        end
        set_op(3, 32'd9, 32'd9);
        req_valid[3] = 1'b1;
        serve(3, 32'd81, 1'b1, "abrt_r3");

        // pointer wrapped to 0: 0 beats 3, then 3 is served
        set_op(0, 32'd2, 32'd4);
        set_op(3, 32'd6, 32'd7);
        req_valid = 4'b1001;
        serve(0, 32'd8, 1'b1, "wrap0");
        serve(3, 32'd42, 1'b1, "wrap3");
        #1;
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
